// File: rtl/i2c_slave.sv
// Single-address I2C target: oversampled SCL/SDA, START/STOP decode, and a bridge
// from I2C bytes to a register strobe bus (pointer byte, then data; auto-increment reads).
module i2c_slave #(
   parameter logic [6:0]  DEV_ADDR = 7'h50,
   parameter int unsigned SDA_HOLD = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_o,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_wr,
   output logic       reg_rd,
   input  logic [7:0] reg_rdata,
   output logic       busy
);

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
      S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK
   } state_t;

   localparam logic [7:0] HOLD_LD = 8'(SDA_HOLD);

   logic [2:0] scl_q, sda_q;
   state_t     state_q, state_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [6:0] rx_q, rx_d;
   logic [7:0] tx_q, tx_d;
   logic       rw_q, rw_d;
   logic       ack_drv_q, ack_drv_d;
   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic       sda_o_q, sda_o_d;
   logic [7:0] reg_addr_q, reg_addr_d;
   logic [7:0] reg_wdata_q, reg_wdata_d;
   logic       reg_wr_q, reg_wr_d;
   logic       reg_rd_q, reg_rd_d;
   logic       rd_next_q, rd_next_d;
   logic [1:0] rd_pipe_q;
   logic       busy_q, busy_d;

   logic       sda_s, scl_rise, scl_fall, start_det, stop_det, hold_fire;
   logic [7:0] rx_byte;

   // Index 1 is the synchronized level, index 2 its previous value for edge detection.
   assign sda_s     = sda_q[1];
   assign scl_rise  = scl_q[1] & ~scl_q[2];
   assign scl_fall  = ~scl_q[1] & scl_q[2];
   assign start_det = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
   assign stop_det  = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
   assign hold_fire = (hold_cnt_q == 8'd1);
   assign rx_byte   = {rx_q, sda_s};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_q       <= 3'b111;
         sda_q       <= 3'b111;
         state_q     <= S_IDLE;
         bit_cnt_q   <= 4'd0;
         rx_q        <= 7'd0;
         tx_q        <= 8'd0;
         rw_q        <= 1'b0;
         ack_drv_q   <= 1'b0;
         hold_cnt_q  <= 8'd0;
         sda_o_q     <= 1'b1;
         reg_addr_q  <= 8'd0;
         reg_wdata_q <= 8'd0;
         reg_wr_q    <= 1'b0;
         reg_rd_q    <= 1'b0;
         rd_next_q   <= 1'b0;
         rd_pipe_q   <= 2'b00;
         busy_q      <= 1'b0;
      end else begin
         scl_q       <= {scl_q[1:0], scl_i};
         sda_q       <= {sda_q[1:0], sda_i};
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         rw_q        <= rw_d;
         ack_drv_q   <= ack_drv_d;
         hold_cnt_q  <= hold_cnt_d;
         sda_o_q     <= sda_o_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         reg_wr_q    <= reg_wr_d;
         reg_rd_q    <= reg_rd_d;
         rd_next_q   <= rd_next_d;
         rd_pipe_q   <= {rd_pipe_q[0], reg_rd_q};
         busy_q      <= busy_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      rx_d        = rx_q;
      tx_d        = tx_q;
      rw_d        = rw_q;
      ack_drv_d   = ack_drv_q;
      sda_o_d     = sda_o_q;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      reg_wr_d    = 1'b0;
      reg_rd_d    = rd_next_q;
      rd_next_d   = 1'b0;
      busy_d      = busy_q;
      hold_cnt_d  = hold_cnt_q;

      if (scl_fall)
         hold_cnt_d = HOLD_LD;
      else if (hold_cnt_q != 8'd0)
         hold_cnt_d = hold_cnt_q - 8'd1;

      // Read data arrives exactly two cycles after the strobe; the write pointer
      // advances the cycle after a write strobe.
      if (rd_pipe_q[1])
         tx_d = reg_rdata;
      if (reg_wr_q)
         reg_addr_d = reg_addr_q + 8'd1;

      if (start_det) begin
         state_d   = S_ADDR;
         bit_cnt_d = 4'd0;
         sda_o_d   = 1'b1;
         busy_d    = 1'b0;
         ack_drv_d = 1'b0;
      end else if (stop_det) begin
         state_d   = S_IDLE;
         bit_cnt_d = 4'd0;
         sda_o_d   = 1'b1;
         busy_d    = 1'b0;
         ack_drv_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: ;
            S_ADDR, S_PTR, S_WR_DATA: begin
               if (scl_rise) begin
                  rx_d      = rx_byte[6:0];
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     bit_cnt_d = 4'd0;
                     ack_drv_d = 1'b0;
                     if (state_q == S_ADDR) begin
                        if (rx_q == DEV_ADDR) begin
                           rw_d     = sda_s;
                           reg_rd_d = sda_s;
                           busy_d   = 1'b1;
                           state_d  = S_ADDR_ACK;
                        end else begin
                           state_d = S_IDLE;
                        end
                     end else if (state_q == S_PTR) begin
                        reg_addr_d = rx_byte;
                        state_d    = S_PTR_ACK;
                     end else begin
                        reg_wdata_d = rx_byte;
                        reg_wr_d    = 1'b1;
                        state_d     = S_WR_ACK;
                     end
                  end
               end
            end
            S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: begin
               // First hold expiry (8th fall) pulls low, second (9th fall) leaves the ACK slot.
               if (hold_fire) begin
                  if (!ack_drv_q) begin
                     sda_o_d   = 1'b0;
                     ack_drv_d = 1'b1;
                  end else begin
                     ack_drv_d = 1'b0;
                     sda_o_d   = 1'b1;
                     bit_cnt_d = 4'd0;
                     if (state_q == S_ADDR_ACK && rw_q) begin
                        sda_o_d = tx_q[7];
                        state_d = S_RD_DATA;
                     end else if (state_q == S_ADDR_ACK) begin
                        state_d = S_PTR;
                     end else begin
                        state_d = S_WR_DATA;
                     end
                  end
               end
            end
            S_RD_DATA: begin
               if (hold_fire) begin
                  if (bit_cnt_q == 4'd7) begin
                     sda_o_d   = 1'b1;
                     bit_cnt_d = 4'd0;
                     ack_drv_d = 1'b0;
                     state_d   = S_RD_ACK;
                  end else begin
                     sda_o_d   = tx_q[6];
                     tx_d      = {tx_q[6:0], 1'b0};
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            S_RD_ACK: begin
               // ack_drv_q marks "master ACKed; next byte starts at the 9th fall".
               if (!ack_drv_q && scl_rise) begin
                  if (!sda_s) begin
                     reg_addr_d = reg_addr_q + 8'd1;
                     rd_next_d  = 1'b1;
                     ack_drv_d  = 1'b1;
                  end else begin
                     busy_d  = 1'b0;
                     state_d = S_IDLE;
                  end
               end else if (ack_drv_q && hold_fire) begin
                  sda_o_d   = tx_q[7];
                  ack_drv_d = 1'b0;
                  bit_cnt_d = 4'd0;
                  state_d   = S_RD_DATA;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign sda_o     = sda_o_q;
   assign reg_addr  = reg_addr_q;
   assign reg_wdata = reg_wdata_q;
   assign reg_wr    = reg_wr_q;
   assign reg_rd    = reg_rd_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged I2C master, a register model with
// two-cycle read latency, and strobe logging compared against hand-computed values.
`timescale 1ns/1ps
module tb_i2c_slave;

   localparam int HQ = 10;   // quarter SCL period in clk cycles
   localparam int H  = 2 * HQ;

   typedef enum logic [2:0] {OP_START, OP_STOP, OP_WR, OP_RDA, OP_RDN, OP_ADDR, OP_BUSY} op_e;
   typedef struct packed {
      op_e        op;
      logic [7:0] din;
      logic [7:0] exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_o;
   logic [7:0] reg_addr, reg_wdata, reg_rdata;
   logic       reg_wr, reg_rd, busy;
   wire        sda_line = sda_m & sda_o;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0]  mem [256];
   logic        v1 = 1'b0, v2 = 1'b0;
   logic [7:0]  a1 = 8'd0, a2 = 8'd0;
   logic [15:0] wr_log[$];
   logic [7:0]  rd_log[$];
   int          sda_low_cnt = 0;
   int          busy_hi_cnt = 0;

   always #5 clk = ~clk;

   i2c_slave #(.DEV_ADDR(7'h50), .SDA_HOLD(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .scl_i     (scl_m),
      .sda_i     (sda_line),
      .sda_o     (sda_o),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_wr    (reg_wr),
      .reg_rd    (reg_rd),
      .reg_rdata (reg_rdata),
      .busy      (busy)
   );

   // Register model: data is valid only in the cycle exactly two cycles after reg_rd.
   always @(posedge clk) begin
      v1 <= reg_rd;
      a1 <= reg_addr;
      v2 <= v1;
      a2 <= a1;
   end
   assign reg_rdata = v2 ? mem[a2] : 8'h00;

   always @(negedge clk) begin
      if (rst_n) begin
         if (reg_wr) wr_log.push_back({reg_addr, reg_wdata});
         if (reg_rd) rd_log.push_back(reg_addr);
         if (!sda_o) sda_low_cnt++;
         if (busy) busy_hi_cnt++;
      end
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end else begin
         $display("ok   %s: %h", nm, act);
      end
   endtask

   task automatic hc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; hc(HQ);
      scl_m = 1'b1; hc(HQ);
      sda_m = 1'b0; hc(HQ);
      scl_m = 1'b0; hc(HQ);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; hc(HQ);
      scl_m = 1'b1; hc(HQ);
      sda_m = 1'b1; hc(H);
   endtask

   task automatic bit_xfer(input logic b, output logic r);
      sda_m = b;    hc(HQ);
      scl_m = 1'b1; hc(HQ);
      r = sda_line; hc(HQ);
      scl_m = 1'b0; hc(HQ);
   endtask

   task automatic wr_byte(input logic [7:0] d, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
      bit_xfer(1'b1, r);
      ack = ~r;
   endtask

   task automatic rd_byte(input logic mack, output logic [7:0] d);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, r);
         d[i] = r;
      end
      bit_xfer(~mack, r);
   endtask

   vec_t vecs[$];
   logic ack;
   logic [7:0] rbyte;
   logic dummy;
   int wr0, rd0, low0, busy0;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i);
      mem[8'h20] = 8'h5A;
      mem[8'h21] = 8'hC3;

      hc(3);
      chk("reset sda_o", 16'(sda_o), 16'h1);
      chk("reset busy", 16'(busy), 16'h0);
      chk("reset reg_addr", 16'(reg_addr), 16'h0);
      chk("reset reg_wdata", 16'(reg_wdata), 16'h0);
      chk("reset reg_wr", 16'(reg_wr), 16'h0);
      chk("reset reg_rd", 16'(reg_rd), 16'h0);
      rst_n = 1'b1;
      hc(5);

      // Write 0xA5, 0x3C at pointer 0x10
      vecs.push_back('{OP_START, 8'h00, 8'h00});
      vecs.push_back('{OP_WR,    8'hA0, 8'h01});
      vecs.push_back('{OP_BUSY,  8'h00, 8'h01});
      vecs.push_back('{OP_WR,    8'h10, 8'h01});
      vecs.push_back('{OP_WR,    8'hA5, 8'h01});
      vecs.push_back('{OP_WR,    8'h3C, 8'h01});
      vecs.push_back('{OP_STOP,  8'h00, 8'h00});
      vecs.push_back('{OP_ADDR,  8'h00, 8'h12});
      vecs.push_back('{OP_BUSY,  8'h00, 8'h00});
      // Pointer 0x20, repeated START, read two bytes (ACK then NACK)
      vecs.push_back('{OP_START, 8'h00, 8'h00});
      vecs.push_back('{OP_WR,    8'hA0, 8'h01});
      vecs.push_back('{OP_WR,    8'h20, 8'h01});
      vecs.push_back('{OP_START, 8'h00, 8'h00});
      vecs.push_back('{OP_WR,    8'hA1, 8'h01});
      vecs.push_back('{OP_BUSY,  8'h00, 8'h01});
      vecs.push_back('{OP_RDA,   8'h00, 8'h5A});
      vecs.push_back('{OP_RDN,   8'h00, 8'hC3});
      vecs.push_back('{OP_BUSY,  8'h00, 8'h00});
      vecs.push_back('{OP_STOP,  8'h00, 8'h00});
      vecs.push_back('{OP_ADDR,  8'h00, 8'h21});
      // Pointer wrap 0xFF -> 0x00
      vecs.push_back('{OP_START, 8'h00, 8'h00});
      vecs.push_back('{OP_WR,    8'hA0, 8'h01});
      vecs.push_back('{OP_WR,    8'hFF, 8'h01});
      vecs.push_back('{OP_WR,    8'h11, 8'h01});
      vecs.push_back('{OP_WR,    8'h22, 8'h01});
      vecs.push_back('{OP_STOP,  8'h00, 8'h00});
      vecs.push_back('{OP_ADDR,  8'h00, 8'h01});

      foreach (vecs[i]) begin
         case (vecs[i].op)
            OP_START: i2c_start();
            OP_STOP:  i2c_stop();
            OP_WR: begin
               wr_byte(vecs[i].din, ack);
               chk($sformatf("vec%0d ack of %h", i, vecs[i].din), 16'(ack), 16'(vecs[i].exp));
            end
            OP_RDA, OP_RDN: begin
               rd_byte(vecs[i].op == OP_RDA, rbyte);
               chk($sformatf("vec%0d read byte", i), 16'(rbyte), 16'(vecs[i].exp));
            end
            OP_ADDR: chk($sformatf("vec%0d reg_addr", i), 16'(reg_addr), 16'(vecs[i].exp));
            OP_BUSY: chk($sformatf("vec%0d busy", i), 16'(busy), 16'(vecs[i].exp));
            default: ;
         endcase
      end

      chk("reg_wr count", 16'(wr_log.size()), 16'd4);
      if (wr_log.size() == 4) begin
         chk("wr0 addr/data", wr_log[0], 16'h10A5);
         chk("wr1 addr/data", wr_log[1], 16'h113C);
         chk("wr2 addr/data", wr_log[2], 16'hFF11);
         chk("wr3 addr/data", wr_log[3], 16'h0022);
      end
      chk("reg_rd count", 16'(rd_log.size()), 16'd2);
      if (rd_log.size() == 2) begin
         chk("rd0 addr", 16'(rd_log[0]), 16'h0020);
         chk("rd1 addr", 16'(rd_log[1]), 16'h0021);
      end

      // Address mismatch (0x51/W): fully ignored
      wr0 = wr_log.size(); rd0 = rd_log.size(); low0 = sda_low_cnt; busy0 = busy_hi_cnt;
      i2c_start();
      wr_byte(8'hA2, ack); chk("mismatch addr ack", 16'(ack), 16'h0);
      wr_byte(8'h33, ack); chk("mismatch data0 ack", 16'(ack), 16'h0);
      wr_byte(8'h44, ack); chk("mismatch data1 ack", 16'(ack), 16'h0);
      i2c_stop();
      chk("mismatch sda low cycles", 16'(sda_low_cnt - low0), 16'h0);
      chk("mismatch strobes", 16'((wr_log.size() - wr0) + (rd_log.size() - rd0)), 16'h0);
      chk("mismatch busy cycles", 16'(busy_hi_cnt - busy0), 16'h0);

      // STOP after 4 bits of a data byte
      wr0 = wr_log.size();
      i2c_start();
      wr_byte(8'hA0, ack); chk("abort addr ack", 16'(ack), 16'h1);
      wr_byte(8'h40, ack); chk("abort ptr ack", 16'(ack), 16'h1);
      bit_xfer(1'b1, dummy); bit_xfer(1'b0, dummy);
      bit_xfer(1'b1, dummy); bit_xfer(1'b1, dummy);
      i2c_stop();
      chk("abort no reg_wr", 16'(wr_log.size() - wr0), 16'h0);
      chk("abort sda_o", 16'(sda_o), 16'h1);
      chk("abort busy", 16'(busy), 16'h0);
      chk("abort ptr kept", 16'(reg_addr), 16'h0040);
      scl_m = 1'b0; hc(HQ);
      wr_byte(8'hA0, ack); chk("idle ignores byte w/o START", 16'(ack), 16'h0);
      i2c_stop();

      // Reset while the slave drives the address ACK
      i2c_start();
      for (int i = 7; i >= 0; i--) bit_xfer(((8'hA0 >> i) & 8'h01) != 0, dummy);
      sda_m = 1'b1; hc(HQ);
      scl_m = 1'b1; hc(HQ);
      chk("ack driven before reset", 16'(sda_line), 16'h0);
      rst_n = 1'b0;
      #1;
      chk("async reset sda_o", 16'(sda_o), 16'h1);
      chk("async reset reg_addr", 16'(reg_addr), 16'h0);
      chk("async reset busy", 16'(busy), 16'h0);
      hc(4);
      rst_n = 1'b1;
      hc(5);
      i2c_start();
      wr_byte(8'hA0, ack); chk("post-reset addr ack", 16'(ack), 16'h1);
      wr_byte(8'h05, ack); chk("post-reset ptr ack", 16'(ack), 16'h1);
      wr_byte(8'h77, ack); chk("post-reset data ack", 16'(ack), 16'h1);
      i2c_stop();
      chk("post-reset write", (wr_log.size() > 0) ? wr_log[$] : 16'hxxxx, 16'h0577);
      chk("post-reset reg_addr", 16'(reg_addr), 16'h0006);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
